// File: rtl/cov_matrix_accum_if.sv
// Sample-in / matrix-out handshake bundle for the covariance accumulator.
// The master is the side that feeds samples and consumes results.
interface cov_matrix_accum_if #(
   parameter int N_CH = 2,
   parameter int DW   = 8
);
   logic                       I_start;
   logic                       I_mode;
   logic                       I_sample_valid;
   logic                       O_sample_ready;
   logic [N_CH*DW-1:0]         I_sample_data;
   logic [N_CH*N_CH*2*DW-1:0]  O_rx_data;
   logic                       O_rx_valid;
   logic                       I_rx_ready;
   logic                       O_busy;
   logic                       O_overflow;

   modport master (
      output I_start, I_mode, I_sample_valid, I_sample_data, I_rx_ready,
      input  O_sample_ready, O_rx_data, O_rx_valid, O_busy, O_overflow
   );

   modport slave (
      input  I_start, I_mode, I_sample_valid, I_sample_data, I_rx_ready,
      output O_sample_ready, O_rx_data, O_rx_valid, O_busy, O_overflow
   );
endinterface

// File: rtl/cov_matrix_accum.sv
// N-channel sample-covariance accumulator: sums x*x^T over a 2^LOG2_LEN window
// and presents the window mean as a full symmetric N_CH x N_CH matrix.
module cov_matrix_accum #(
   parameter int N_CH     = 2,
   parameter int DW       = 8,
   parameter int LOG2_LEN = 12
) (
   input logic               I_sys_clk,
   input logic               I_sys_rstn,
   cov_matrix_accum_if.slave bus
);
   localparam int NP = N_CH * (N_CH + 1) / 2;
   localparam int PW = 2 * DW;
   localparam int AW = PW + LOG2_LEN;

   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   state_t               state;
   logic                 mode_q;
   logic [LOG2_LEN-1:0]  sample_cnt;
   logic                 p1_valid;
   logic                 p1_last;
   logic                 acc_last;
   logic                 rx_valid_q;
   logic                 overflow_q;
   logic                 accept;
   logic                 is_last;

   logic signed [PW-1:0] prod_d [NP];
   logic signed [PW-1:0] prod_q [NP];
   logic signed [AW-1:0] acc_q  [NP];
   logic signed [PW-1:0] res_q  [NP];

   assign accept             = bus.I_sample_valid && (state == ACC);
   assign is_last            = (sample_cnt == {LOG2_LEN{1'b1}});
   assign bus.O_sample_ready = (state == ACC);
   assign bus.O_rx_valid     = rx_valid_q;
   assign bus.O_overflow     = overflow_q;
   assign bus.O_busy         = (state == ACC) || p1_valid || acc_last;

   // Only the upper triangle is computed; K packs (i,j), i<=j, row by row and
   // the lower-triangle output slots mirror the same result register.
   for (genvar gi = 0; gi < N_CH; gi++) begin : g_row
      for (genvar gj = gi; gj < N_CH; gj++) begin : g_col
         localparam int K = gi * N_CH - (gi * (gi - 1)) / 2 + (gj - gi);
         assign prod_d[K] = PW'($signed(bus.I_sample_data[gi*DW +: DW]))
                          * PW'($signed(bus.I_sample_data[gj*DW +: DW]));
         assign bus.O_rx_data[(gi*N_CH+gj)*PW +: PW] = res_q[K];
         if (gj != gi) begin : g_mirror
            assign bus.O_rx_data[(gj*N_CH+gi)*PW +: PW] = res_q[K];
         end
      end
   end

   // Control FSM plus the two-stage product/accumulate pipeline. A window's
   // final sum sits in acc_q with acc_last set; on the next edge it moves to the
   // output register while acc_q restarts from the product already waiting in
   // stage 1, so continuous windows need no gap cycle.
   always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
      if (!I_sys_rstn) begin
         state      <= IDLE;
         mode_q     <= 1'b0;
         sample_cnt <= '0;
         p1_valid   <= 1'b0;
         p1_last    <= 1'b0;
         acc_last   <= 1'b0;
         rx_valid_q <= 1'b0;
         overflow_q <= 1'b0;
         for (int k = 0; k < NP; k++) begin
            prod_q[k] <= '0;
            acc_q[k]  <= '0;
            res_q[k]  <= '0;
         end
      end else begin
         if (bus.I_rx_ready) rx_valid_q <= 1'b0;

         if (bus.I_start) begin
            state      <= ACC;
            mode_q     <= bus.I_mode;
            sample_cnt <= '0;
            p1_valid   <= 1'b0;
            p1_last    <= 1'b0;
            acc_last   <= 1'b0;
            overflow_q <= 1'b0;
            for (int k = 0; k < NP; k++) acc_q[k] <= '0;
         end else begin
            p1_valid <= accept;
            p1_last  <= accept && is_last;
            acc_last <= p1_valid && p1_last;

            if (accept) begin
               sample_cnt <= sample_cnt + LOG2_LEN'(1);
               for (int k = 0; k < NP; k++) prod_q[k] <= prod_d[k];
               if (is_last && !mode_q) state <= HOLD;
            end

            for (int k = 0; k < NP; k++) begin
               if (acc_last)
                  acc_q[k] <= p1_valid ? AW'(prod_q[k]) : '0;
               else if (p1_valid)
                  acc_q[k] <= acc_q[k] + AW'(prod_q[k]);
            end

            // A result landing on a still-unaccepted one replaces it and flags loss.
            if (acc_last) begin
               for (int k = 0; k < NP; k++) res_q[k] <= PW'(acc_q[k] >>> LOG2_LEN);
               rx_valid_q <= 1'b1;
               if (rx_valid_q && !bus.I_rx_ready) overflow_q <= 1'b1;
            end

            if (state == HOLD && !rx_valid_q && !p1_valid && !acc_last) state <= IDLE;
         end
      end
   end
endmodule
